// File: rtl/dca_matrix_load2mreg_pkg.sv
// Shared definitions for the load-to-mreg stage: matrix dimension helpers,
// default widths and the FSM state encoding.
package dca_matrix_load2mreg_pkg;

  localparam int DEFAULT_MATRIX_SIZE_PARA = 4;
  localparam int DEFAULT_BW_TENSOR_SCALAR = 32;

  // Square matrices: the size selector maps directly to the row/column count.
  function automatic int matrix_num_row(input int size_para);
    return (size_para < 1) ? 1 : size_para;
  endfunction

  function automatic int matrix_num_col(input int size_para);
    return (size_para < 1) ? 1 : size_para;
  endfunction

  localparam int DEFAULT_BW_TENSOR_ROW =
    matrix_num_col(DEFAULT_MATRIX_SIZE_PARA) * DEFAULT_BW_TENSOR_SCALAR;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } load2mreg_state_t;

endpackage

// File: rtl/dca_matrix_load2mreg_counter.sv
// One-hot row counter: starts at bit 0, rotates left on each count and wraps
// back to bit 0 after the last position.
module dca_matrix_load2mreg_counter #(
  parameter int COUNT_LENGTH = 4
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    clear,
  input  logic                    count,
  output logic [COUNT_LENGTH-1:0] value,
  output logic                    is_last_count
);

  localparam logic [COUNT_LENGTH-1:0] INIT_VALUE = COUNT_LENGTH'(1);

  logic [COUNT_LENGTH-1:0] value_next;

  assign value_next[0] = value[COUNT_LENGTH-1];
  generate
    for (genvar gi = 1; gi < COUNT_LENGTH; gi++) begin : g_rotate
      assign value_next[gi] = value[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      value <= INIT_VALUE;
    end else if (clear) begin
      value <= INIT_VALUE;
    end else if (count) begin
      value <= value_next;
    end
  end

  assign is_last_count = value[COUNT_LENGTH-1];

endmodule

// File: rtl/dca_matrix_load2mreg.sv
// Streams tensor rows into the matrix register, zero-padding short tensors.
// Optional overflow drain: define DCA_MATRIX_LOAD2MREG_OVERFLOW_DRAIN_EN.
module dca_matrix_load2mreg
  import dca_matrix_load2mreg_pkg::*;
#(
  parameter int  MATRIX_SIZE_PARA = DEFAULT_MATRIX_SIZE_PARA,
  parameter int  BW_TENSOR_SCALAR = DEFAULT_BW_TENSOR_SCALAR,
  localparam int MATRIX_NUM_ROW   = matrix_num_row(MATRIX_SIZE_PARA),
  localparam int MATRIX_NUM_COL   = matrix_num_col(MATRIX_SIZE_PARA),
  localparam int BW_TENSOR_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     enable,
  output logic                     busy,
  output logic                     loadreg_wready,
  input  logic                     loadreg_wrequest,
  input  logic                     load_tensor_row_wvalid,
  input  logic                     load_tensor_row_wlast,
  output logic                     load_tensor_row_wready,
  input  logic [BW_TENSOR_ROW-1:0] load_tensor_row_wdata,
  output logic                     mreg_move_wenable,
  output logic [BW_TENSOR_ROW-1:0] mreg_move_wdata_list1d,
  output logic                     error_overflow
);

  load2mreg_state_t state_reg, state_next;

  logic                      hs;
  logic                      count_row;
  logic                      last_count;
  logic [MATRIX_NUM_ROW-1:0] row_onehot;

  dca_matrix_load2mreg_counter #(
    .COUNT_LENGTH (MATRIX_NUM_ROW)
  ) i_row_counter (
    .clk           (clk),
    .rstnn         (rstnn),
    .clear         (clear),
    .count         (count_row),
    .value         (row_onehot),
    .is_last_count (last_count)
  );

`ifdef DCA_MATRIX_LOAD2MREG_OVERFLOW_DRAIN_EN
  assign load_tensor_row_wready = enable & ((state_reg == ST_LOAD) | (state_reg == ST_DRAIN));
`else
  assign load_tensor_row_wready = enable & (state_reg == ST_LOAD);
`endif

  assign hs             = load_tensor_row_wvalid & load_tensor_row_wready;
  assign busy           = (state_reg != ST_IDLE);
  assign loadreg_wready = (state_reg == ST_IDLE);

  // Pad rows carry zeros; only live LOAD writes forward the upstream payload.
  assign mreg_move_wdata_list1d = (mreg_move_wenable && state_reg == ST_LOAD) ?
                                  load_tensor_row_wdata : '0;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef DCA_MATRIX_LOAD2MREG_OVERFLOW_DRAIN_EN
  logic drain_enter;
  logic error_overflow_reg;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      error_overflow_reg <= 1'b0;
    end else if (clear) begin
      error_overflow_reg <= 1'b0;
    end else if (drain_enter) begin
      error_overflow_reg <= 1'b1;
    end
  end

  assign error_overflow = error_overflow_reg;
`else
  assign error_overflow = 1'b0;
`endif

  always_comb begin
    state_next        = state_reg;
    mreg_move_wenable = 1'b0;
    count_row         = 1'b0;
`ifdef DCA_MATRIX_LOAD2MREG_OVERFLOW_DRAIN_EN
    drain_enter       = 1'b0;
`endif
    if (clear) begin
      state_next = ST_IDLE;
    end else if (enable) begin
      case (state_reg)
        ST_IDLE: begin
          if (loadreg_wrequest) state_next = ST_LOAD;
        end
        ST_LOAD: begin
          if (hs) begin
            mreg_move_wenable = 1'b1;
            count_row         = 1'b1;
            if (load_tensor_row_wlast) begin
              state_next = last_count ? ST_IDLE : ST_PAD;
            end else if (last_count) begin
`ifdef DCA_MATRIX_LOAD2MREG_OVERFLOW_DRAIN_EN
              state_next  = ST_DRAIN;
              drain_enter = 1'b1;
`else
              state_next  = ST_IDLE;
`endif
            end
          end
        end
        ST_PAD: begin
          mreg_move_wenable = 1'b1;
          count_row         = 1'b1;
          if (last_count) state_next = ST_IDLE;
        end
        default: begin
`ifdef DCA_MATRIX_LOAD2MREG_OVERFLOW_DRAIN_EN
          if (hs && load_tensor_row_wlast) state_next = ST_IDLE;
`else
          state_next = ST_IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dca_matrix_load2mreg.sv
// Directed bench for dca_matrix_load2mreg (4x4, 32-bit scalars) with a
// scoreboard of expected mreg writes checked by a negedge monitor.
module tb_dca_matrix_load2mreg;

  localparam int ROW_W = 128;

  logic             clk;
  logic             rstnn;
  logic             clear;
  logic             enable;
  logic             busy;
  logic             loadreg_wready;
  logic             loadreg_wrequest;
  logic             load_tensor_row_wvalid;
  logic             load_tensor_row_wlast;
  logic             load_tensor_row_wready;
  logic [ROW_W-1:0] load_tensor_row_wdata;
  logic             mreg_move_wenable;
  logic [ROW_W-1:0] mreg_move_wdata_list1d;
  logic             error_overflow;

  int checks = 0;
  int errors = 0;
  int write_count = 0;
  int writes_before;
  logic [ROW_W-1:0] exp_q[$];
  logic [ROW_W-1:0] row_a, row_b, row_c, row_d, row_e, row_f;

  dca_matrix_load2mreg dut (
    .clk                    (clk),
    .rstnn                  (rstnn),
    .clear                  (clear),
    .enable                 (enable),
    .busy                   (busy),
    .loadreg_wready         (loadreg_wready),
    .loadreg_wrequest       (loadreg_wrequest),
    .load_tensor_row_wvalid (load_tensor_row_wvalid),
    .load_tensor_row_wlast  (load_tensor_row_wlast),
    .load_tensor_row_wready (load_tensor_row_wready),
    .load_tensor_row_wdata  (load_tensor_row_wdata),
    .mreg_move_wenable      (mreg_move_wenable),
    .mreg_move_wdata_list1d (mreg_move_wdata_list1d),
    .error_overflow         (error_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: every mreg write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstnn) begin
      if (mreg_move_wenable) begin
        write_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", mreg_move_wdata_list1d, {ROW_W{1'bx}});
        end else begin
          chk("mreg_wdata", mreg_move_wdata_list1d, exp_q.pop_front());
        end
        chk("wenable_while_disabled", {127'd0, enable}, {127'd0, 1'b1});
      end else begin
        chk("wdata_idle_zero", mreg_move_wdata_list1d, '0);
      end
    end
  end

  task automatic request_load();
    @(posedge clk); #1;
    loadreg_wrequest = 1'b1;
    @(posedge clk); #1;
    loadreg_wrequest = 1'b0;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] d, input logic l);
    int n;
    n = 0;
    load_tensor_row_wvalid = 1'b1;
    load_tensor_row_wdata  = d;
    load_tensor_row_wlast  = l;
    @(negedge clk);
    while (!load_tensor_row_wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("row_accept", {127'd0, load_tensor_row_wready}, {127'd0, 1'b1});
    @(posedge clk); #1;
    load_tensor_row_wvalid = 1'b0;
    load_tensor_row_wlast  = 1'b0;
    load_tensor_row_wdata  = '0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, {127'd0, busy}, '0);
    chk({tag, "_loadreg_wready"}, {127'd0, loadreg_wready}, {127'd0, 1'b1});
    chk({tag, "_queue_empty"}, ROW_W'(exp_q.size()), '0);
  endtask

  initial begin
    row_a = {4{32'hA000_00A1}};
    row_b = {4{32'hB000_00B2}};
    row_c = {4{32'hC000_00C3}};
    row_d = {4{32'hD000_00D4}};
    row_e = {4{32'hE000_00E5}};
    row_f = {4{32'hF000_00F6}};
    rstnn = 1'b0;
    clear = 1'b0;
    enable = 1'b1;
    loadreg_wrequest = 1'b0;
    load_tensor_row_wvalid = 1'b0;
    load_tensor_row_wlast = 1'b0;
    load_tensor_row_wdata = '0;
    #23 rstnn = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", {127'd0, busy}, '0);
    chk("rst_loadreg_wready", {127'd0, loadreg_wready}, {127'd0, 1'b1});
    chk("rst_row_wready", {127'd0, load_tensor_row_wready}, '0);
    chk("rst_wenable", {127'd0, mreg_move_wenable}, '0);
    chk("rst_error", {127'd0, error_overflow}, '0);

    // Full load A..D
    writes_before = write_count;
    request_load();
    chk("load_busy", {127'd0, busy}, {127'd0, 1'b1});
    exp_q.push_back(row_a); exp_q.push_back(row_b);
    exp_q.push_back(row_c); exp_q.push_back(row_d);
    send_row(row_a, 1'b0);
    send_row(row_b, 1'b0);
    send_row(row_c, 1'b0);
    send_row(row_d, 1'b1);
    check_idle("full");
    chk("full_writes", ROW_W'(write_count - writes_before), ROW_W'(4));

    // Short tensor: two rows, then two zero pad rows on consecutive cycles
    writes_before = write_count;
    request_load();
    exp_q.push_back(row_a); exp_q.push_back(row_b);
    exp_q.push_back('0);    exp_q.push_back('0);
    send_row(row_a, 1'b0);
    send_row(row_b, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_idle("short");
    chk("short_writes", ROW_W'(write_count - writes_before), ROW_W'(4));

    // Backpressure gaps plus enable held low
    writes_before = write_count;
    request_load();
    exp_q.push_back(row_a); exp_q.push_back(row_b);
    exp_q.push_back(row_c); exp_q.push_back(row_d);
    send_row(row_a, 1'b0);
    @(posedge clk); #1;
    enable = 1'b0;
    load_tensor_row_wvalid = 1'b1;
    load_tensor_row_wdata = row_b;
    @(negedge clk);
    chk("dis_row_wready", {127'd0, load_tensor_row_wready}, '0);
    chk("dis_wenable", {127'd0, mreg_move_wenable}, '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dis_busy_held", {127'd0, busy}, {127'd0, 1'b1});
    @(posedge clk); #1;
    enable = 1'b1;
    send_row(row_b, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send_row(row_c, 1'b0);
    send_row(row_d, 1'b1);
    check_idle("bp");
    chk("bp_writes", ROW_W'(write_count - writes_before), ROW_W'(4));

    // Overflow: six rows offered, only four written
    writes_before = write_count;
    request_load();
    exp_q.push_back(row_a); exp_q.push_back(row_b);
    exp_q.push_back(row_c); exp_q.push_back(row_d);
    send_row(row_a, 1'b0);
    send_row(row_b, 1'b0);
    send_row(row_c, 1'b0);
    send_row(row_d, 1'b0);
`ifdef DCA_MATRIX_LOAD2MREG_OVERFLOW_DRAIN_EN
    @(negedge clk);
    chk("ovf_error_set", {127'd0, error_overflow}, {127'd0, 1'b1});
    send_row(row_e, 1'b0);
    send_row(row_f, 1'b1);
    check_idle("ovf");
    chk("ovf_error_sticky", {127'd0, error_overflow}, {127'd0, 1'b1});
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("ovf_error_cleared", {127'd0, error_overflow}, '0);
`else
    load_tensor_row_wvalid = 1'b1;
    load_tensor_row_wdata = row_e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_row_wready_low", {127'd0, load_tensor_row_wready}, '0);
    end
    chk("ovf_error_zero", {127'd0, error_overflow}, '0);
    @(posedge clk); #1;
    load_tensor_row_wvalid = 1'b0;
    load_tensor_row_wdata = '0;
    check_idle("ovf");
`endif
    chk("ovf_writes", ROW_W'(write_count - writes_before), ROW_W'(4));

    // Clear mid-load, then a fresh full load
    request_load();
    exp_q.push_back(row_a); exp_q.push_back(row_b);
    send_row(row_a, 1'b0);
    send_row(row_b, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_idle("clr");
    writes_before = write_count;
    request_load();
    exp_q.push_back(row_c); exp_q.push_back(row_d);
    exp_q.push_back(row_e); exp_q.push_back(row_f);
    send_row(row_c, 1'b0);
    send_row(row_d, 1'b0);
    send_row(row_e, 1'b0);
    send_row(row_f, 1'b1);
    check_idle("clr_reload");
    repeat (3) @(negedge clk);
    chk("clr_reload_writes", ROW_W'(write_count - writes_before), ROW_W'(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
